// File: rtl/uart_tx_serializer.sv
// UART transmit serializer running in the divided bit-clock domain.
// Frames a parallel word as start, LSB-first data, optional parity and stop bits.
// Every output is registered.
module uart_tx_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [DATA_W-1:0] I_data,
  input  logic              I_data_valid,
  input  logic              I_par_en,
  input  logic              I_par_typ,
  output logic              o_tx_out,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic              par_en_q;
  logic              par_bit;

  // Frame sequencer: state names the bit currently on the line.
  // On each edge, the next bit is loaded into o_tx_out.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      par_en_q     <= 1'b0;
      par_bit      <= 1'b0;
      o_tx_out     <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_out <= 1'b1;
          o_busy   <= 1'b0;
          if (I_data_valid) begin
            // Parity configuration is captured once; mid-frame changes cannot alter the frame.
            shreg    <= I_data;
            par_en_q <= I_par_en;
            par_bit  <= I_par_typ ? ~^I_data : ^I_data;
            bit_cnt  <= '0;
            o_tx_out <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          o_tx_out <= shreg[0];
          shreg    <= shreg >> 1;
          bit_cnt  <= '0;
          state    <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (par_en_q) begin
              o_tx_out <= par_bit;
              state    <= PARITY;
            end else begin
              o_tx_out <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end else begin
            o_tx_out <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          o_tx_out <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
        STOP: begin
          o_tx_out <= 1'b1;
          if (stop_cnt == STOP_LAST) begin
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          o_tx_out <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one instance with one stop bit and
// one instance with two stop bits. Outputs are sampled on the falling edge.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       par_en1, par_typ1, par_en2, par_typ2;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  int vectors;
  int errors;

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(1)) dut1 (
    .I_clk(clk), .I_rst(rst), .I_data(data1), .I_data_valid(valid1),
    .I_par_en(par_en1), .I_par_typ(par_typ1),
    .o_tx_out(tx1), .o_busy(busy1), .o_frame_done(done1)
  );

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(2)) dut2 (
    .I_clk(clk), .I_rst(rst), .I_data(data2), .I_data_valid(valid2),
    .I_par_en(par_en2), .I_par_typ(par_typ2),
    .o_tx_out(tx2), .o_busy(busy2), .o_frame_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Send one frame on dut1. seq holds the line in transmission order, first bit at seq[n-1].
  // When inj >= 0, a competing valid with 8'hFF and par_en=1 is driven during bit inj.
  task automatic run_frame1(input string tag, input logic [7:0] d, input logic pe,
                            input logic pt, input logic [15:0] seq, input int n,
                            input int inj);
    data1 = d; par_en1 = pe; par_typ1 = pt; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_tx"}, tx1, seq[n-1-i]);
      check({tag, "_busy"}, busy1, 1'b1);
      check({tag, "_nodone"}, done1, 1'b0);
      if (i == inj) begin
        data1 = 8'hFF; par_en1 = 1'b1; valid1 = 1'b1;
      end else begin
        valid1 = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_idle_tx"}, tx1, 1'b1);
    check({tag, "_idle_busy"}, busy1, 1'b0);
    check({tag, "_done"}, done1, 1'b1);
    @(negedge clk);
    check({tag, "_after_done"}, done1, 1'b0);
    check({tag, "_after_busy"}, busy1, 1'b0);
    check({tag, "_after_tx"}, tx1, 1'b1);
  endtask

  initial begin
    vectors = 0; errors = 0;
    rst = 1'b1;
    data1 = '0; valid1 = 1'b0; par_en1 = 1'b0; par_typ1 = 1'b0;
    data2 = '0; valid2 = 1'b0; par_en2 = 1'b0; par_typ2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", tx1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset during the start bit pulls the line high without an edge
    data1 = 8'h00; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    check("t1_start_tx", tx1, 1'b0);
    check("t1_start_busy", busy1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_tx", tx1, 1'b1);
    check("t1_async_busy", busy1, 1'b0);
    check("t1_async_done", done1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8'hA5 without parity, then with even and odd parity
    run_frame1("t2_a5", 8'hA5, 1'b0, 1'b0, 16'(10'b0101001011), 10, -1);
    run_frame1("t3_even", 8'hA5, 1'b1, 1'b0, 16'(11'b01010010101), 11, -1);
    run_frame1("t3_odd", 8'hA5, 1'b1, 1'b1, 16'(11'b01010010111), 11, -1);

    // Valid during data is dropped; par_en toggle mid-frame keeps length
    run_frame1("t4_3c", 8'h3C, 1'b0, 1'b0, 16'(10'b0001111001), 10, 3);
    par_en1 = 1'b0;
    @(negedge clk);
    check("t4_no_queue_busy", busy1, 1'b0);
    check("t4_no_queue_tx", tx1, 1'b1);

    // Reset during data bit 3 of 8'h0F, then a clean 8'h81 frame
    data1 = 8'h0F; valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_bit3_tx", tx1, 1'b1);
    check("t5_bit3_busy", busy1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_tx", tx1, 1'b1);
    check("t5_async_busy", busy1, 1'b0);
    @(negedge clk);
    check("t5_hold_tx", tx1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_tx", tx1, 1'b1);
    check("t5_post_busy", busy1, 1'b0);
    check("t5_no_done", done1, 1'b0);
    run_frame1("t5_81", 8'h81, 1'b0, 1'b0, 16'(10'b0100000011), 10, -1);

    // Two stop bits, valid held: 8'h55 then 8'hAA with one idle cycle between
    data2 = 8'h55; valid2 = 1'b1;
    @(negedge clk);
    data2 = 8'hAA;
    for (int i = 0; i < 11; i++) begin
      check("t6_55_tx", tx2, 1'(11'b01010101011 >> (10 - i)));
      check("t6_55_busy", busy2, 1'b1);
      check("t6_55_nodone", done2, 1'b0);
      @(negedge clk);
    end
    check("t6_gap_tx", tx2, 1'b1);
    check("t6_gap_busy", busy2, 1'b0);
    check("t6_gap_done", done2, 1'b1);
    @(negedge clk);
    valid2 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check("t6_aa_tx", tx2, 1'(11'b00101010111 >> (10 - i)));
      check("t6_aa_busy", busy2, 1'b1);
      check("t6_aa_nodone", done2, 1'b0);
      @(negedge clk);
    end
    check("t6_end_done", done2, 1'b1);
    check("t6_end_busy", busy2, 1'b0);
    @(negedge clk);
    check("t6_idle_busy", busy2, 1'b0);
    check("t6_idle_done", done2, 1'b0);
    check("t6_idle_tx", tx2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
